mux_4x1_rr_arbiter: RTL
=======================

// Module: mux_4x1_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for a shared 4:1 selection path. Four
//   requesters compete for one output channel. The block picks an owner and
//   drives the 4:1 mux selects (s0 = MSB, s1 = LSB). It registers the selected
//   data word and enforces a maximum hold time so no requester starves.
// PARAMETERS
//   DATA_W    8   width of each requester data word and of dout
//   MAX_HOLD  4   max consecutive grant cycles while others wait (>=1)
// PORTS
//   clk       in   1          single clock, rising edge
//   rst_n     in   1          asynchronous, active-low reset
//   req       in   4          request per requester, level; held until served
//   din0      in   DATA_W     requester 0 data
//   din1      in   DATA_W     requester 1 data
//   din2      in   DATA_W     requester 2 data
//   din3      in   DATA_W     requester 3 data
//   gnt       out  4          one-hot grant, registered; 0 when idle
//   s0        out  1          mux select MSB = owner[1]
//   s1        out  1          mux select LSB = owner[0]
//   busy      out  1          1 while in GRANT state
//   dout      out  DATA_W     registered data from current owner
//   dout_vld  out  1          dout holds a transferred word this cycle
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - state=IDLE, gnt=0, s0=s1=0, busy=0, dout=0, dout_vld=0, hold_cnt=0.
//     - rr pointer=3, so requester 0 has top priority first.
//     - Mid-transfer reset aborts immediately; no word is emitted after it.
//   Search
//     - Search the req bits circularly from pointer+1: 0->1->2->3->0.
//     - pointer <= the new owner at every grant.
//   IDLE
//     - req==0: stay in IDLE.
//     - Else: on the next edge go to GRANT, owner=winner, hold_cnt=1.
//     - gnt/s0/s1 update on that same edge, so grant latency is 1 clk from req.
//   GRANT, each edge
//     - Transfer: if req[owner]=1, dout<=din[owner] and dout_vld<=1; else dout_vld<=0.
//       Word latency: 1 clk from the sampled cycle. dout holds its value when no transfer.
//     - Release: req[owner]=0.
//       Others pending: switch to the next RR winner on the same edge (no
//       bubble), hold_cnt=1. Otherwise go to IDLE, gnt=0.
//       s0/s1 keep the last owner in IDLE.
//     - Preempt: hold_cnt==MAX_HOLD and any other req pending.
//       Switch to the next RR winner, hold_cnt=1.
//       The preempted requester keeps req high and is re-served in RR order.
//     - Otherwise stay with the same owner; hold_cnt increments and saturates
//       at MAX_HOLD.
//   - Only the owner is sampled; the din of non-owners is ignored.
//   - gnt is always one-hot or zero, and gnt==(1<<{s0,s1}) whenever busy=1.
//   - Width rule: hold_cnt is $clog2(MAX_HOLD+1) bits; no wrap.
// TESTING
//   1. Reset: rst_n=0 with req=4'hF.
//      -> gnt=0, dout_vld=0, busy=0.
//      After release, first gnt=4'b0001, {s0,s1}=2'b00.
//   2. Single request: req=4'b0100, din2=8'hA5, held 3 clks.
//      -> gnt=4'b0100 after 1 clk, {s0,s1}=2'b10.
//      dout=8'hA5 with dout_vld=1 for 3 clks.
//      req drops -> IDLE, gnt=0.
//   3. All requesting: req=4'hF, MAX_HOLD=4, held continuously.
//      -> grants rotate 0,1,2,3,0, 4 clks each.
//      dout_vld stays 1 with no gaps.
//   4. Early release: owner 1 drops req after 2 clks while req3 pending.
//      -> gnt moves 4'b0010 -> 4'b1000 on the same edge, no idle cycle.
//   5. Lone owner past MAX_HOLD: req=4'b0001 for 10 clks.
//      -> gnt stays 4'b0001, hold_cnt saturates at 4.
//      Raising req[2] then -> gnt=4'b0100 next clk.
//   6. Async reset mid-transfer: rst_n low between edges during GRANT.
//      -> gnt, dout_vld and busy clear immediately without waiting for clk.
//      After release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/mux_4x1_rr_arbiter.sv
// mux_4x1_rr_arbiter: round-robin owner selection for a shared 4:1 path with registered data and bounded hold
// Ports: clk/rst_n (async active-low); req[3:0] level requests; din0..din3 requester data;
//        gnt one-hot grant; s0/s1 mux selects (owner MSB/LSB); busy in GRANT;
//        dout/dout_vld registered word taken from the current owner.
module mux_4x1_rr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic [3:0]        gnt,
  output logic              s0,
  output logic              s1,
  output logic              busy,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t            state_q;
  logic [1:0]        owner_q, ptr_q, win_d, idx;
  logic [HW-1:0]     hold_q;
  logic [3:0]        gnt_q;
  logic [DATA_W-1:0] dout_q, sel_din;
  logic              vld_q, found, others, hold_max, own_req;
  // Circular search starting just after the pointer; the pointer itself is checked last.
  always_comb begin
    win_d = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        win_d = idx;
        found = 1'b1;
      end
    end
  end
  assign own_req  = req[owner_q];
  assign others   = |(req & ~(4'b0001 << owner_q));
  assign hold_max = hold_q == HW'(MAX_HOLD);
  assign sel_din  = owner_q == 2'd0 ? din0 : owner_q == 2'd1 ? din1 : owner_q == 2'd2 ? din2 : din3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd3;
      hold_q  <= '0;
      gnt_q   <= 4'b0000;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          vld_q <= 1'b0;
          if (|req) begin
            state_q <= GRANT;
            owner_q <= win_d;
            ptr_q   <= win_d;
            hold_q  <= HW'(1);
            gnt_q   <= 4'b0001 << win_d;
          end
        end
        GRANT: begin
          vld_q <= own_req;
          if (own_req) dout_q <= sel_din;
          if (!own_req && !others) begin
            state_q <= IDLE;
            hold_q  <= '0;
            gnt_q   <= 4'b0000;
          end else if (!own_req || (hold_max && others)) begin
            // Release with others waiting, or hold limit reached: hand over without a bubble.
            owner_q <= win_d;
            ptr_q   <= win_d;
            hold_q  <= HW'(1);
            gnt_q   <= 4'b0001 << win_d;
          end else if (!hold_max) begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt      = gnt_q;
  assign s0       = owner_q[1];
  assign s1       = owner_q[0];
  assign busy     = state_q == GRANT;
  assign dout     = dout_q;
  assign dout_vld = vld_q;
endmodule
